systolic_output_deskew: RTL and testbench

- Receive side of the systolic array, the counterpart of the Systolic_Data_Setup input skewer.
- Lane i of the array output presents its element i cycles after lane 0. This block delays each lane so the lanes line up again, then pushes one aligned row per beat into a small show-ahead FIFO.
- The FIFO drains over a valid/ready handshake towards the writeback/buffer logic.
- Sticky flags report skew mismatches and FIFO overflow, because the array cannot be stalled mid-wavefront.

---
 rtl/systolic_output_deskew.sv | 147 ++++++++++++++
 tb/tb_systolic_output_deskew.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_deskew.sv
// rtl/systolic_output_deskew.sv - re-aligns skewed systolic array lanes into a show-ahead row FIFO
// Optional OUTPUT_RELU_EN clamps negative lane values to zero at FIFO write.
module systolic_output_deskew #(
   parameter int DATA_WIDTH = 32,
   parameter int SA_LENGTH  = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               CLK,
   input  logic                               SYNC_RST,
   input  logic                               EN,
   input  logic [DATA_WIDTH-1:0]              In_Data [SA_LENGTH],
   input  logic [SA_LENGTH-1:0]               In_Valid,
   output logic [DATA_WIDTH-1:0]              Out_Data [SA_LENGTH],
   output logic                               Out_Valid,
   input  logic                               Out_Ready,
   output logic                               Skew_Error,
   output logic                               Overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    Row_Count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [DATA_WIDTH-1:0] lane_data [SA_LENGTH];
   logic [SA_LENGTH-1:0]  lane_valid;

   // Lane i waits SA_LENGTH-1-i beats so every lane lines up with the last one.
   for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
      localparam int D = SA_LENGTH - 1 - i;
      if (D == 0) begin : g_pass
         assign lane_data[i]  = In_Data[i];
         assign lane_valid[i] = In_Valid[i];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] data_q [D];
         logic [D-1:0]          valid_q;
         always_ff @(posedge CLK) begin
            if (!SYNC_RST) begin
               for (int k = 0; k < D; k++) begin
                  data_q[k] <= '0;
               end
               valid_q <= '0;
            end else if (EN) begin
               data_q[0]  <= In_Data[i];
               valid_q[0] <= In_Valid[i];
               for (int k = 1; k < D; k++) begin
                  data_q[k]  <= data_q[k-1];
                  valid_q[k] <= valid_q[k-1];
               end
            end
         end
         assign lane_data[i]  = data_q[D-1];
         assign lane_valid[i] = valid_q[D-1];
      end
   end

   logic [DATA_WIDTH-1:0] wr_row  [SA_LENGTH];
   logic [DATA_WIDTH-1:0] mem_q   [FIFO_DEPTH][SA_LENGTH];
   logic [DATA_WIDTH-1:0] last_q  [SA_LENGTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  skew_q, skew_d, ovf_q, ovf_d;
   logic                  aligned_v, any_v, empty, full, pop, push_req, push;

   always_comb begin
      for (int i = 0; i < SA_LENGTH; i++) begin
         wr_row[i] = lane_data[i];
`ifdef OUTPUT_RELU_EN
         if (lane_data[i][DATA_WIDTH-1]) begin
            wr_row[i] = '0;
         end
`endif
      end
   end

   assign aligned_v = &lane_valid;
   assign any_v     = |lane_valid;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign pop       = !empty && Out_Ready;
   assign push_req  = EN && aligned_v;
   // A full FIFO still accepts a row when the head leaves on the same edge.
   assign push      = push_req && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      skew_d   = skew_q | (EN & any_v & ~aligned_v);
      ovf_d    = ovf_q | (push_req & ~push);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!SYNC_RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         skew_q   <= 1'b0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < SA_LENGTH; i++) begin
            last_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         skew_q   <= skew_d;
         ovf_q    <= ovf_d;
         if (pop) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
               last_q[i] <= mem_q[rd_ptr_q][i];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RST && push) begin
         for (int i = 0; i < SA_LENGTH; i++) begin
            mem_q[wr_ptr_q][i] <= wr_row[i];
         end
      end
   end

   // An empty FIFO keeps presenting the most recently consumed row.
   always_comb begin
      for (int i = 0; i < SA_LENGTH; i++) begin
         Out_Data[i] = empty ? last_q[i] : mem_q[rd_ptr_q][i];
      end
   end

   assign Out_Valid  = !empty;
   assign Skew_Error = skew_q;
   assign Overflow   = ovf_q;
   assign Row_Count  = count_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb/tb_systolic_output_deskew.sv - directed self-checking bench for systolic_output_deskew
// Rows are captured at the falling edge whenever a handshake will complete.
module tb_systolic_output_deskew;

   localparam int DW = 32;
   localparam int SA = 5;
   localparam int FD = 4;
   localparam int CW = $clog2(FD+1);

   logic          CLK = 1'b0;
   logic          SYNC_RST = 1'b0;
   logic          EN = 1'b1;
   logic [DW-1:0] In_Data [SA];
   logic [SA-1:0] In_Valid = '0;
   logic [DW-1:0] Out_Data [SA];
   logic          Out_Valid;
   logic          Out_Ready = 1'b0;
   logic          Skew_Error;
   logic          Overflow;
   logic [CW-1:0] Row_Count;

   systolic_output_deskew #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .FIFO_DEPTH(FD)) dut (
      .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .In_Data(In_Data), .In_Valid(In_Valid),
      .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Skew_Error(Skew_Error), .Overflow(Overflow), .Row_Count(Row_Count)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic signed [DW-1:0] vals [8][SA];
   logic [SA*DW-1:0] cap_row [$];
   int cap_cyc [$];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      logic [SA*DW-1:0] p;
      if (SYNC_RST && Out_Valid && Out_Ready) begin
         for (int i = 0; i < SA; i++) p[i*DW +: DW] = Out_Data[i];
         cap_row.push_back(p);
         cap_cyc.push_back(cyc);
      end
   end

   function automatic logic [SA*DW-1:0] exp_row(input int base, input int r);
      logic [SA*DW-1:0] p;
      for (int i = 0; i < SA; i++) p[i*DW +: DW] = DW'(base + r*10 + i);
      return p;
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic fill_vals(input int base, input int n);
      for (int r = 0; r < n; r++)
         for (int i = 0; i < SA; i++) vals[r][i] = DW'(base + r*10 + i);
   endtask

   task automatic set_lanes(input int c, input int n, input int late);
      for (int i = 0; i < SA; i++) begin
         int r;
         r = c - i - ((i == late) ? 1 : 0);
         if (r >= 0 && r < n) begin
            In_Valid[i] = 1'b1;
            In_Data[i]  = vals[r][i];
         end else begin
            In_Valid[i] = 1'b0;
            In_Data[i]  = '0;
         end
      end
   endtask

   task automatic idle_lanes;
      In_Valid = '0;
      for (int i = 0; i < SA; i++) In_Data[i] = '0;
   endtask

   task automatic drive_wave(input int n, input int late, input int freeze_c, input int pulse_c,
                             input logic rdy, output int start);
      start = cyc;
      for (int c = 0; c < n + SA - 1 + ((late >= 0) ? 1 : 0); c++) begin
         set_lanes(c, n, late);
         Out_Ready = (c == pulse_c) ? 1'b1 : rdy;
         if (c == freeze_c) begin
            EN = 1'b0;
            repeat (3) tick();
            EN = 1'b1;
         end
         tick();
      end
      idle_lanes();
      Out_Ready = rdy;
   endtask

   task automatic do_reset;
      SYNC_RST  = 1'b0;
      EN        = 1'b1;
      Out_Ready = 1'b1;
      idle_lanes();
      repeat (2) tick();
      SYNC_RST = 1'b1;
      cap_row.delete();
      cap_cyc.delete();
   endtask

   task automatic test_reset;
      logic [SA*DW-1:0] p;
      do_reset();
      for (int i = 0; i < SA; i++) p[i*DW +: DW] = Out_Data[i];
      n_cmp++; if (p !== '0) begin n_bad++; $display("FAIL reset_out_data got=%h want=0", p); end
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid k=%0d got=%b want=0", k, Out_Valid); end
         n_cmp++; if (Row_Count !== '0) begin n_bad++; $display("FAIL idle_count k=%0d got=%0d want=0", k, Row_Count); end
         n_cmp++; if (Skew_Error !== 1'b0) begin n_bad++; $display("FAIL idle_skew k=%0d got=%b want=0", k, Skew_Error); end
         n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL idle_ovf k=%0d got=%b want=0", k, Overflow); end
         tick();
      end
   endtask

   task automatic test_single_wavefront;
      int st;
      do_reset();
      fill_vals(10, 1);
      drive_wave(1, -1, -1, -1, 1'b1, st);
      repeat (4) tick();
      n_cmp++; if (cap_row.size() != 1) begin n_bad++; $display("FAIL single_rows got=%0d want=1", cap_row.size()); end
      if (cap_row.size() >= 1) begin
         n_cmp++; if (cap_row[0] !== exp_row(10, 0)) begin n_bad++; $display("FAIL single_data got=%h want=%h", cap_row[0], exp_row(10, 0)); end
         n_cmp++; if (cap_cyc[0] != st + 5) begin n_bad++; $display("FAIL single_latency got=%0d want=%0d", cap_cyc[0], st + 5); end
      end
      n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop got=%b want=0", Out_Valid); end
      n_cmp++; if (Skew_Error !== 1'b0) begin n_bad++; $display("FAIL single_skew got=%b want=0", Skew_Error); end
   endtask

   task automatic test_back_to_back;
      int st;
      do_reset();
      fill_vals(0, 6);
      drive_wave(6, -1, -1, -1, 1'b1, st);
      repeat (4) tick();
      n_cmp++; if (cap_row.size() != 6) begin n_bad++; $display("FAIL b2b_rows got=%0d want=6", cap_row.size()); end
      for (int r = 0; r < 6 && r < cap_row.size(); r++) begin
         n_cmp++; if (cap_row[r] !== exp_row(0, r)) begin n_bad++; $display("FAIL b2b_data r=%0d got=%h want=%h", r, cap_row[r], exp_row(0, r)); end
         n_cmp++; if (cap_cyc[r] != st + 5 + r) begin n_bad++; $display("FAIL b2b_cycle r=%0d got=%0d want=%0d", r, cap_cyc[r], st + 5 + r); end
      end
      n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b want=0", Overflow); end
      n_cmp++; if (Row_Count !== '0) begin n_bad++; $display("FAIL b2b_count got=%0d want=0", Row_Count); end
   endtask

   task automatic test_overflow;
      int st;
      do_reset();
      Out_Ready = 1'b0;
      fill_vals(0, 5);
      drive_wave(5, -1, -1, -1, 1'b0, st);
      n_cmp++; if (Row_Count !== CW'(4)) begin n_bad++; $display("FAIL ovf_count got=%0d want=4", Row_Count); end
      n_cmp++; if (Overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", Overflow); end
      n_cmp++; if (Out_Valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got=%b want=1", Out_Valid); end
      fill_vals(90, 1);
      drive_wave(1, -1, -1, 4, 1'b0, st);
      n_cmp++; if (Row_Count !== CW'(4)) begin n_bad++; $display("FAIL full_pushpop_count got=%0d want=4", Row_Count); end
      n_cmp++; if (Overflow !== 1'b1) begin n_bad++; $display("FAIL full_pushpop_ovf got=%b want=1", Overflow); end
      Out_Ready = 1'b1;
      repeat (6) tick();
      n_cmp++; if (cap_row.size() != 5) begin n_bad++; $display("FAIL drain_rows got=%0d want=5", cap_row.size()); end
      for (int r = 0; r < 4 && r < cap_row.size(); r++) begin
         n_cmp++; if (cap_row[r] !== exp_row(0, r)) begin n_bad++; $display("FAIL drain_data r=%0d got=%h want=%h", r, cap_row[r], exp_row(0, r)); end
      end
      if (cap_row.size() >= 5) begin
         n_cmp++; if (cap_row[4] !== exp_row(90, 0)) begin n_bad++; $display("FAIL drain_late_row got=%h want=%h", cap_row[4], exp_row(90, 0)); end
      end
      n_cmp++; if (Row_Count !== '0) begin n_bad++; $display("FAIL drain_count got=%0d want=0", Row_Count); end
   endtask

   task automatic test_skew_fault;
      int st;
      do_reset();
      fill_vals(20, 1);
      drive_wave(1, 2, -1, -1, 1'b1, st);
      repeat (3) tick();
      n_cmp++; if (Skew_Error !== 1'b1) begin n_bad++; $display("FAIL skew_flag got=%b want=1", Skew_Error); end
      n_cmp++; if (cap_row.size() != 0) begin n_bad++; $display("FAIL skew_rows got=%0d want=0", cap_row.size()); end
      n_cmp++; if (Row_Count !== '0) begin n_bad++; $display("FAIL skew_count got=%0d want=0", Row_Count); end
   endtask

   task automatic test_en_freeze;
      int st;
      do_reset();
      fill_vals(30, 1);
      drive_wave(1, -1, 2, -1, 1'b1, st);
      repeat (4) tick();
      n_cmp++; if (cap_row.size() != 1) begin n_bad++; $display("FAIL freeze_rows got=%0d want=1", cap_row.size()); end
      if (cap_row.size() >= 1) begin
         n_cmp++; if (cap_row[0] !== exp_row(30, 0)) begin n_bad++; $display("FAIL freeze_data got=%h want=%h", cap_row[0], exp_row(30, 0)); end
         n_cmp++; if (cap_cyc[0] != st + 8) begin n_bad++; $display("FAIL freeze_latency got=%0d want=%0d", cap_cyc[0], st + 8); end
      end
      n_cmp++; if (Skew_Error !== 1'b0) begin n_bad++; $display("FAIL freeze_skew got=%b want=0", Skew_Error); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      fill_vals(40, 1);
      for (int c = 0; c < 3; c++) begin
         set_lanes(c, 1, -1);
         tick();
      end
      set_lanes(3, 1, -1);
      SYNC_RST = 1'b0;
      tick();
      SYNC_RST = 1'b1;
      idle_lanes();
      repeat (10) tick();
      n_cmp++; if (cap_row.size() != 0) begin n_bad++; $display("FAIL midrst_rows got=%0d want=0", cap_row.size()); end
      n_cmp++; if (Row_Count !== '0) begin n_bad++; $display("FAIL midrst_count got=%0d want=0", Row_Count); end
      n_cmp++; if (Skew_Error !== 1'b0) begin n_bad++; $display("FAIL midrst_skew got=%b want=0", Skew_Error); end
   endtask

   task automatic test_relu;
      int st;
      logic [SA*DW-1:0] want;
      logic signed [DW-1:0] in_v [SA];
      logic signed [DW-1:0] ex_v [SA];
      in_v[0] = -5; in_v[1] = 3; in_v[2] = -1; in_v[3] = 0; in_v[4] = 7;
`ifdef OUTPUT_RELU_EN
      ex_v[0] = 0;  ex_v[1] = 3; ex_v[2] = 0;  ex_v[3] = 0; ex_v[4] = 7;
`else
      ex_v[0] = -5; ex_v[1] = 3; ex_v[2] = -1; ex_v[3] = 0; ex_v[4] = 7;
`endif
      for (int i = 0; i < SA; i++) begin
         vals[0][i] = in_v[i];
         want[i*DW +: DW] = ex_v[i];
      end
      do_reset();
      drive_wave(1, -1, -1, -1, 1'b1, st);
      repeat (4) tick();
      n_cmp++; if (cap_row.size() != 1) begin n_bad++; $display("FAIL relu_rows got=%0d want=1", cap_row.size()); end
      if (cap_row.size() >= 1) begin
         n_cmp++; if (cap_row[0] !== want) begin n_bad++; $display("FAIL relu_data got=%h want=%h", cap_row[0], want); end
      end
   endtask

   initial begin
      for (int i = 0; i < SA; i++) In_Data[i] = '0;
      test_reset();
      test_single_wavefront();
      test_back_to_back();
      test_overflow();
      test_skew_fault();
      test_en_freeze();
      test_reset_mid();
      test_relu();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
